fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controls the 12-bit program counter register of the single-issue processor. Decides each cycle whether the PC holds, advances by one, or loads a redirect target: jump, taken branch, or exception vector. Holds the front end while a multi-cycle mult/div operation runs and applies a timeout to that wait. Sits between decode/execute control signals and the instruction-memory address port.

## Interface
Parameters:
- `EXC_VECTOR`, default 12'd4095: PC loaded on exception or mult/div timeout.
- `MD_TIMEOUT`, default 64: maximum number of cycles spent in `MD_WAIT` before a timeout.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `exception`  in  1  execute-stage exception request.
- `jump`  in  1  unconditional jump request (j/jal/jr).
- `jump_target`  in  12  jump destination.
- `branch_taken`  in  1  resolved taken branch.
- `branch_target`  in  12  branch destination.
- `md_start`  in  1  mult/div operation issued this cycle.
- `md_ready`  in  1  mult/div result valid.
- `halt_instr`  in  1  halt instruction decoded.
- `pc_addr`  out  12  current PC, used as the instruction-memory address.
- `fetch_valid`  out  1  `pc_addr` is a live fetch this cycle.
- `flush`  out  1  squash in-flight younger instructions.
- `stall`  out  1  freeze the pipeline registers upstream of execute.
- `md_timeout`  out  1  one-cycle pulse when the mult/div wait times out.
- `halted`  out  1  sequencer is in `HALTED`.

## Operation
- States: `BOOT`, `RUN`, `MD_WAIT`, `HALTED`.
- `BOOT`: entered on reset. PC held at 0; `fetch_valid`=0. Moves unconditionally to `RUN` on the next edge.
- `RUN`: evaluates requests in strict priority order; only the first active request takes effect:
  1. `exception`: PC←`EXC_VECTOR`, `flush`=1.
  2. `jump`: PC←`jump_target`, `flush`=1.
  3. `branch_taken`: PC←`branch_target`, `flush`=1.
  4. `md_start`: PC holds, `stall`=1, go to `MD_WAIT`, wait counter←0.
  5. `halt_instr`: PC holds, go to `HALTED`.
  6. No request: PC←PC+1 modulo 4096, so 12'hFFF wraps to 12'h000.
- `MD_WAIT`:
  - Counter increments every cycle.
  - If `md_ready`=1: PC←PC+1, `stall`=0, go to `RUN`.
  - Else, if counter = `MD_TIMEOUT`-1: PC←`EXC_VECTOR`, `flush`=1, `md_timeout`=1, go to `RUN`.
  - Otherwise: PC holds, `stall`=1.
  - If `md_ready` and timeout occur in the same cycle, `md_ready` wins.
  - `exception`, `jump`, `branch_taken` and `halt_instr` are ignored in this state.
- `HALTED`: PC holds, `fetch_valid`=0, `halted`=1. Only reset exits this state.
- The counter is wide enough to hold `MD_TIMEOUT`-1 and saturates; it never wraps.

## Timing
- Reset values: `pc_addr`=0, state=`BOOT`, counter=0, `fetch_valid`=0, `flush`=0, `stall`=0, `md_timeout`=0, `halted`=0.
- Reset is asynchronous: asserting it mid-`MD_WAIT` or in `HALTED` returns to `BOOT` immediately.
- `flush`, `stall` and `md_timeout` are combinational from the current state and inputs. They are asserted in the same cycle as the request that causes them.
- Each PC update takes effect on the rising edge that ends the deciding cycle, so a redirect target appears on `pc_addr` one cycle after the request.
- `fetch_valid`=1 in `RUN` and `MD_WAIT`, and 0 in `BOOT` and `HALTED`.
- The first valid fetch of address 0 happens in the first `RUN` cycle, which is cycle 2 after reset deasserts.

## Structure
- Shared package `cpu_pkg`: `ADDR_W`=12, the state encoding (2-bit enum), and the default `EXC_VECTOR` constant.
- Sub-module: the existing `pc` register (12-bit, async clear, load enable), instantiated as `u_pc`. Its enable is driven high whenever the PC updates; its input is the selected next PC.
- The next-PC mux and the FSM stay in `fetch_sequencer`.

## Test plan
- Reset then idle for 5 cycles -> `pc_addr` sequence 0,0,1,2,3; `fetch_valid` 0 for the first cycle only.
- In `RUN` at PC=10, assert `jump` (target 200) and `branch_taken` (target 50) in the same cycle -> `flush`=1 that cycle; next `pc_addr`=200.
- In `RUN` at PC=20, assert `md_start`; raise `md_ready` 5 cycles later -> `stall`=1 for 6 cycles, PC holds at 20, then PC=21.
- `md_start` with no `md_ready` and `MD_TIMEOUT`=8 -> `md_timeout` and `flush` pulse in the 8th `MD_WAIT` cycle; next PC=4095.
- PC=4095 with no requests -> next PC=0 (wrap).
- `halt_instr` at PC=7, then assert `jump` -> `halted`=1, PC stays 7, jump ignored; assert reset mid-halt -> PC=0 and state `BOOT` asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared processor constants: address width, fetch sequencer state
// encoding and the default exception vector.
package cpu_pkg;

  localparam int ADDR_W = 12;

  localparam logic [ADDR_W-1:0] EXC_VECTOR_DEFAULT = 12'd4095;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MD_WAIT = 2'd2,
    ST_HALTED  = 2'd3
  } fs_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control bundle between decode/execute and the fetch sequencer.
//
// Request/response semantics: exception, jump, branch_taken, md_start and
// halt_instr are level requests sampled in the cycle they are high; there is
// no back-pressure handshake. The sequencer answers in the same cycle with
// flush/stall/md_timeout (combinational) and the chosen PC appears on
// pc_addr after the next rising clock edge. md_ready is only looked at while
// the sequencer waits on a mult/div operation. dbg_state mirrors the FSM.
interface fetch_sequencer_if;
  import cpu_pkg::*;

  logic              exception;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              md_start;
  logic              md_ready;
  logic              halt_instr;
  logic [ADDR_W-1:0] pc_addr;
  logic              fetch_valid;
  logic              flush;
  logic              stall;
  logic              md_timeout;
  logic              halted;
  fs_state_t         dbg_state;

  // Decode/execute side: raises requests, observes the front end.
  modport master (
    output exception, jump, jump_target, branch_taken, branch_target,
           md_start, md_ready, halt_instr,
    input  pc_addr, fetch_valid, flush, stall, md_timeout, halted, dbg_state
  );

  // Sequencer side.
  modport slave (
    input  exception, jump, jump_target, branch_taken, branch_target,
           md_start, md_ready, halt_instr,
    output pc_addr, fetch_valid, flush, stall, md_timeout, halted, dbg_state
  );

endinterface

// File: rtl/fetch_sequencer_pc.sv
// Program counter register: asynchronous clear to zero, load on enable.
module pc
  import cpu_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Hold the PC unless a new value is loaded this cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: picks hold / advance / redirect for the PC every cycle,
// parks the front end during mult/div and bounds that wait with a timeout.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int                MD_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  fetch_sequencer_if.slave  bus
);

  // Counter only ever needs to reach MD_TIMEOUT-1.
  localparam int CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MD_TIMEOUT - 1);

  fs_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_fetch_valid;
  logic              r_halted;

  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_pc_en;
  logic              w_flush;
  logic              w_stall;
  logic              w_md_timeout;
  logic              w_redirect;
  logic              w_cnt_at_limit;

  assign w_pc_inc       = w_pc + ADDR_W'(1);
  assign w_redirect     = bus.exception | bus.jump | bus.branch_taken;
  assign w_cnt_at_limit = (r_cnt == CNT_LIMIT);

  // Next-PC selection and same-cycle pipeline control.
  always_comb begin
    w_pc_en      = 1'b0;
    w_pc_next    = w_pc;
    w_flush      = 1'b0;
    w_stall      = 1'b0;
    w_md_timeout = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.exception) begin
          w_pc_en   = 1'b1;
          w_pc_next = EXC_VECTOR;
          w_flush   = 1'b1;
        end else if (bus.jump) begin
          w_pc_en   = 1'b1;
          w_pc_next = bus.jump_target;
          w_flush   = 1'b1;
        end else if (bus.branch_taken) begin
          w_pc_en   = 1'b1;
          w_pc_next = bus.branch_target;
          w_flush   = 1'b1;
        end else if (bus.md_start) begin
          w_stall = 1'b1;
        end else if (bus.halt_instr) begin
          w_pc_en = 1'b0;
        end else begin
          w_pc_en   = 1'b1;
          w_pc_next = w_pc_inc;
        end
      end
      ST_MD_WAIT: begin
        // A result arriving on the last allowed cycle still counts.
        if (bus.md_ready) begin
          w_pc_en   = 1'b1;
          w_pc_next = w_pc_inc;
        end else if (w_cnt_at_limit) begin
          w_pc_en      = 1'b1;
          w_pc_next    = EXC_VECTOR;
          w_flush      = 1'b1;
          w_md_timeout = 1'b1;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_pc_en = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with its wait counter and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_BOOT;
      r_cnt         <= '0;
      r_fetch_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state       <= ST_RUN;
          r_fetch_valid <= 1'b1;
        end
        ST_RUN: begin
          if (!w_redirect) begin
            if (bus.md_start) begin
              r_state <= ST_MD_WAIT;
              r_cnt   <= '0;
            end else if (bus.halt_instr) begin
              r_state       <= ST_HALTED;
              r_fetch_valid <= 1'b0;
              r_halted      <= 1'b1;
            end
          end
        end
        ST_MD_WAIT: begin
          if (!w_cnt_at_limit) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (bus.md_ready || w_cnt_at_limit) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_HALTED;
        end
      endcase
    end
  end

  pc #(.W(ADDR_W)) u_pc (
    .clock (clock),
    .reset (reset),
    .i_en  (w_pc_en),
    .i_d   (w_pc_next),
    .o_q   (w_pc)
  );

  assign bus.pc_addr     = w_pc;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.flush       = w_flush;
  assign bus.stall       = w_stall;
  assign bus.md_timeout  = w_md_timeout;
  assign bus.halted      = r_halted;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with MD_TIMEOUT reduced to 8.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt;

  logic [ADDR_W-1:0] exp_q[$];
  logic              exp_fv_q[$];

  fetch_sequencer_if bus();

  fetch_sequencer #(
    .EXC_VECTOR (12'd4095),
    .MD_TIMEOUT (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Checker
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic clear_req();
    bus.exception     = 1'b0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.md_start      = 1'b0;
    bus.md_ready      = 1'b0;
    bus.halt_instr    = 1'b0;
  endtask

  task automatic do_jump(input logic [ADDR_W-1:0] tgt);
    bus.jump        = 1'b1;
    bus.jump_target = tgt;
    @(negedge clock);
    clear_req();
  endtask

  initial begin
    clear_req();
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Reset state
    check_eq("rst_pc", bus.pc_addr, 0);
    check_eq("rst_state", bus.dbg_state, ST_BOOT);
    check_eq("rst_fv", bus.fetch_valid, 0);
    check_eq("rst_flush", bus.flush, 0);
    check_eq("rst_stall", bus.stall, 0);
    check_eq("rst_mdto", bus.md_timeout, 0);
    check_eq("rst_halted", bus.halted, 0);

    // Idle run after reset: pc 0,0,1,2,3 and fetch_valid 0,1,1,1,1
    reset = 1'b0;
    exp_q    = '{12'd0, 12'd0, 12'd1, 12'd2, 12'd3};
    exp_fv_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("boot_pc", bus.pc_addr, exp_q.pop_front());
      check_eq("boot_fv", bus.fetch_valid, exp_fv_q.pop_front());
      @(negedge clock);
    end
    check_eq("idle_pc4", bus.pc_addr, 4);

    // Move to PC=10
    do_jump(12'd10);
    check_eq("jump10_pc", bus.pc_addr, 10);

    // Jump beats branch
    bus.jump = 1'b1; bus.jump_target = 12'd200;
    bus.branch_taken = 1'b1; bus.branch_target = 12'd50;
    #1;
    check_eq("jb_flush", bus.flush, 1);
    check_eq("jb_stall", bus.stall, 0);
    @(negedge clock);
    clear_req();
    check_eq("jb_pc", bus.pc_addr, 200);

    // Exception beats jump, then wrap from 4095
    bus.exception = 1'b1; bus.jump = 1'b1; bus.jump_target = 12'd5;
    #1;
    check_eq("exc_flush", bus.flush, 1);
    @(negedge clock);
    clear_req();
    check_eq("exc_pc", bus.pc_addr, 4095);
    #1;
    check_eq("wrap_flush", bus.flush, 0);
    @(negedge clock);
    check_eq("wrap_pc", bus.pc_addr, 0);

    // Branch alone
    bus.branch_taken = 1'b1; bus.branch_target = 12'd50;
    #1;
    check_eq("br_flush", bus.flush, 1);
    @(negedge clock);
    clear_req();
    check_eq("br_pc", bus.pc_addr, 50);

    // md_start at PC=20 (beats halt), ready in the 6th wait cycle
    do_jump(12'd20);
    check_eq("md_pc0", bus.pc_addr, 20);
    bus.md_start = 1'b1; bus.halt_instr = 1'b1;
    #1;
    check_eq("md_start_stall", bus.stall, 1);
    check_eq("md_start_flush", bus.flush, 0);
    stall_cnt = int'(bus.stall);
    @(negedge clock);
    clear_req();
    for (int i = 0; i < 5; i++) begin
      bus.exception = 1'b1; bus.jump = 1'b1; bus.jump_target = 12'd99;
      #1;
      check_eq("mdw_stall", bus.stall, 1);
      check_eq("mdw_flush", bus.flush, 0);
      check_eq("mdw_pc", bus.pc_addr, 20);
      check_eq("mdw_state", bus.dbg_state, ST_MD_WAIT);
      check_eq("mdw_fv", bus.fetch_valid, 1);
      stall_cnt += int'(bus.stall);
      @(negedge clock);
    end
    clear_req();
    bus.md_ready = 1'b1;
    #1;
    check_eq("mdr_stall", bus.stall, 0);
    check_eq("mdr_flush", bus.flush, 0);
    stall_cnt += int'(bus.stall);
    check_eq("md_stall_cycles", stall_cnt, 6);
    @(negedge clock);
    clear_req();
    check_eq("mdr_pc", bus.pc_addr, 21);
    check_eq("mdr_state", bus.dbg_state, ST_RUN);

    // Timeout in the 8th wait cycle
    bus.md_start = 1'b1;
    @(negedge clock);
    clear_req();
    for (int i = 0; i < 7; i++) begin
      #1;
      check_eq("to_wait_mdto", bus.md_timeout, 0);
      check_eq("to_wait_stall", bus.stall, 1);
      @(negedge clock);
    end
    #1;
    check_eq("to_mdto", bus.md_timeout, 1);
    check_eq("to_flush", bus.flush, 1);
    check_eq("to_stall", bus.stall, 0);
    @(negedge clock);
    #1;
    check_eq("to_after_mdto", bus.md_timeout, 0);
    check_eq("to_pc", bus.pc_addr, 4095);
    check_eq("to_state", bus.dbg_state, ST_RUN);

    // md_ready wins over timeout on the same cycle (4095 + 1 wraps)
    bus.md_start = 1'b1;
    @(negedge clock);
    clear_req();
    repeat (7) @(negedge clock);
    bus.md_ready = 1'b1;
    #1;
    check_eq("rt_mdto", bus.md_timeout, 0);
    check_eq("rt_flush", bus.flush, 0);
    @(negedge clock);
    clear_req();
    check_eq("rt_pc", bus.pc_addr, 0);

    // Halt at PC=7, jump ignored, async reset out of halt
    do_jump(12'd7);
    check_eq("h_pc0", bus.pc_addr, 7);
    bus.halt_instr = 1'b1;
    #1;
    check_eq("h_stall", bus.stall, 0);
    check_eq("h_flush", bus.flush, 0);
    @(negedge clock);
    clear_req();
    check_eq("h_halted", bus.halted, 1);
    check_eq("h_fv", bus.fetch_valid, 0);
    check_eq("h_state", bus.dbg_state, ST_HALTED);
    bus.jump = 1'b1; bus.jump_target = 12'd300;
    #1;
    check_eq("h_jump_flush", bus.flush, 0);
    @(negedge clock);
    clear_req();
    check_eq("h_jump_pc", bus.pc_addr, 7);
    check_eq("h_still_halted", bus.halted, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_pc", bus.pc_addr, 0);
    check_eq("ar_state", bus.dbg_state, ST_BOOT);
    check_eq("ar_halted", bus.halted, 0);
    check_eq("ar_fv", bus.fetch_valid, 0);
    @(negedge clock);
    reset = 1'b0;

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
